sm3_pad_core_wrapper: RTL and testbench

//  SM3 message padding stage. Accepts the message as a big-endian byte stream on an

---
 rtl/sm3_pad_core_wrapper.sv | 157 +++++++++++++++
 tb/tb_sm3_pad_core_wrapper.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_pad_core_wrapper.sv
// sm3_pad_core_wrapper
//   SM3 message padding stage. Forwards a big-endian message byte stream and
//   appends the 0x80 marker, zero fill and the 64-bit message bit length, so
//   the output is a whole number of 512-bit blocks. The downstream expansion
//   core throttles the whole stage through pad_otpt_ena.
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   msg_inpt_d                 message beat, byte 0 in the MSBs
//   msg_inpt_vld_byte          valid-byte mask, MSB-first contiguous
//   msg_inpt_vld/lst/rdy       beat handshake and last-beat marker
//   pad_otpt_ena               downstream enable; the output advances only when 1
//   pad_otpt_d/vld/lst         padded beat, valid, final beat of final block
module sm3_pad_core_wrapper #(
  parameter int INPT_DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INPT_DW-1:0]   msg_inpt_d,
  input  logic [INPT_DW/8-1:0] msg_inpt_vld_byte,
  input  logic                 msg_inpt_vld,
  input  logic                 msg_inpt_lst,
  output logic                 msg_inpt_rdy,
  input  logic                 pad_otpt_ena,
  output logic [INPT_DW-1:0]   pad_otpt_d,
  output logic                 pad_otpt_vld,
  output logic                 pad_otpt_lst
);

  localparam int NB        = INPT_DW / 8;
  localparam int BPB       = 512 / INPT_DW;
  localparam int BW_W      = $clog2(BPB);
  localparam int LEN_BEATS = 64 / INPT_DW;
  localparam int NB_W      = $clog2(NB + 1);
  localparam logic [BW_W-1:0] LEN_START = BW_W'(BPB - LEN_BEATS);
  localparam logic [BW_W-1:0] BW_LAST   = BW_W'(BPB - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD, S_LEN} state_t;

  state_t               state_q, state_d;
  logic [60:0]          cnt_q, cnt_d;
  logic [BW_W-1:0]      bw_q, bw_d;
  logic                 owed_q, owed_d;
  logic [INPT_DW-1:0]   d_q, d_d;
  logic                 vld_q, vld_d;
  logic                 lst_q, lst_d;

  logic [NB_W-1:0]      nbytes;
  logic [63:0]          len_bits;
  logic [63:0]          len_shifted;
  logic [BW_W-1:0]      len_idx;

  function automatic logic [NB_W-1:0] popcnt(input logic [NB-1:0] m);
    logic [NB_W-1:0] c;
    c = '0;
    for (int i = 0; i < NB; i++) c = c + NB_W'(m[i]);
    return c;
  endfunction

  // Keep the first n bytes, place 0x80 right after them, zero the rest.
  // With a full mask (n == NB) the beat passes unchanged.
  function automatic logic [INPT_DW-1:0] pad_beat(input logic [INPT_DW-1:0] d,
                                                  input logic [NB_W-1:0]    n);
    logic [INPT_DW-1:0] o;
    o = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(n))       o[INPT_DW-1-8*i -: 8] = d[INPT_DW-1-8*i -: 8];
      else if (i == int'(n)) o[INPT_DW-1-8*i -: 8] = 8'h80;
      else                   o[INPT_DW-1-8*i -: 8] = 8'h00;
    end
    return o;
  endfunction

  assign msg_inpt_rdy = pad_otpt_ena && ((state_q == S_IDLE) || (state_q == S_DATA));

  // Length beats are taken most-significant word first, indexed by the
  // position inside the length slot.
  assign nbytes      = popcnt(msg_inpt_vld_byte);
  assign len_bits    = {cnt_q, 3'b000};
  assign len_idx     = bw_q - LEN_START;
  assign len_shifted = len_bits >> (INPT_DW * (LEN_BEATS - 1 - int'(len_idx)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bw_d    = bw_q;
    owed_d  = owed_q;
    d_d     = d_q;
    vld_d   = vld_q;
    lst_d   = lst_q;
    if (pad_otpt_ena) begin
      vld_d = 1'b0;
      lst_d = 1'b0;
      case (state_q)
        S_IDLE, S_DATA: begin
          if (msg_inpt_vld) begin
            d_d   = pad_beat(msg_inpt_d, nbytes);
            vld_d = 1'b1;
            bw_d  = bw_q + 1'b1;
            cnt_d = cnt_q + 61'(nbytes);
            if (msg_inpt_lst) begin
              owed_d = (int'(nbytes) == NB);
              // A partial last beat that lands exactly before the length
              // slot needs no fill at all.
              if (!owed_d && (bw_d == LEN_START)) state_d = S_LEN;
              else                                state_d = S_PAD;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_PAD: begin
          d_d    = owed_q ? {8'h80, {(INPT_DW-8){1'b0}}} : '0;
          vld_d  = 1'b1;
          owed_d = 1'b0;
          bw_d   = bw_q + 1'b1;
          if (bw_d == LEN_START) state_d = S_LEN;
        end
        S_LEN: begin
          d_d   = INPT_DW'(len_shifted);
          vld_d = 1'b1;
          bw_d  = bw_q + 1'b1;
          if (bw_q == BW_LAST) begin
            lst_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bw_q    <= '0;
      owed_q  <= 1'b0;
      d_q     <= '0;
      vld_q   <= 1'b0;
      lst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bw_q    <= bw_d;
      owed_q  <= owed_d;
      d_q     <= d_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
    end
  end

  assign pad_otpt_d   = d_q;
  assign pad_otpt_vld = vld_q;
  assign pad_otpt_lst = lst_q;

endmodule

// File: tb/tb_sm3_pad_core_wrapper.sv
module tb_sm3_pad_core_wrapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] msg_inpt_d;
  logic [3:0]  msg_inpt_vld_byte;
  logic        msg_inpt_vld;
  logic        msg_inpt_lst;
  logic        msg_inpt_rdy;
  logic        pad_otpt_ena;
  logic [31:0] pad_otpt_d;
  logic        pad_otpt_vld;
  logic        pad_otpt_lst;

  int total = 0;
  int bad   = 0;

  logic [31:0] outq[$];
  bit          outlst[$];
  int          lst_seen = 0;
  bit          rand_mode = 0;
  logic        prev_vld = 1'b0;
  logic        prev_ena = 1'b1;
  logic [31:0] prev_d = '0;

  always #5 clk = ~clk;

  sm3_pad_core_wrapper #(.INPT_DW(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .msg_inpt_d        (msg_inpt_d),
    .msg_inpt_vld_byte (msg_inpt_vld_byte),
    .msg_inpt_vld      (msg_inpt_vld),
    .msg_inpt_lst      (msg_inpt_lst),
    .msg_inpt_rdy      (msg_inpt_rdy),
    .pad_otpt_ena      (pad_otpt_ena),
    .pad_otpt_d        (pad_otpt_d),
    .pad_otpt_vld      (pad_otpt_vld),
    .pad_otpt_lst      (pad_otpt_lst)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic abort_run(input string tag);
    bad++;
    total++;
    $display("FAIL %s observed=timeout expected=event", tag);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bound expired");
  endtask

  // Collect every beat the downstream consumes; check holds while ena=0.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_vld && !prev_ena) begin
        chk("hold_d", pad_otpt_d, prev_d);
        chk("hold_vld", pad_otpt_vld, 1'b1);
      end
      if (pad_otpt_vld && pad_otpt_ena) begin
        outq.push_back(pad_otpt_d);
        outlst.push_back(pad_otpt_lst);
        if (pad_otpt_lst) lst_seen++;
      end
      prev_vld = pad_otpt_vld;
      prev_ena = pad_otpt_ena;
      prev_d   = pad_otpt_d;
    end else begin
      prev_vld = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      pad_otpt_ena = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic clr();
    outq.delete();
    outlst.delete();
    lst_seen = 0;
  endtask

  task automatic wait_accept();
    int t;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (msg_inpt_rdy) begin
        @(posedge clk);
        #1;
        break;
      end
      t++;
      if (t > 20000) abort_run("accept_timeout");
    end
  endtask

  task automatic send_msg(input int n);
    int beats;
    int rem;
    logic [3:0] m;
    beats = (n + 3) / 4;
    for (int b = 0; b < beats; b++) begin
      rem = n - 4 * b;
      m = 4'hF;
      if (rem < 4) m = m << (4 - rem);
      msg_inpt_d        = 32'h01020304;
      msg_inpt_vld_byte = m;
      msg_inpt_lst      = (b == beats - 1);
      msg_inpt_vld      = 1'b1;
      wait_accept();
    end
    msg_inpt_vld = 1'b0;
    msg_inpt_lst = 1'b0;
  endtask

  task automatic wait_lst();
    int t;
    t = 0;
    while (lst_seen == 0) begin
      @(posedge clk);
      t++;
      if (t > 20000) abort_run("lst_timeout");
    end
    #1;
  endtask

  task automatic run_msg(input int n);
    clr();
    send_msg(n);
    wait_lst();
  endtask

  function automatic logic zero_span(input int lo, input int hi);
    logic z;
    z = 1'b1;
    for (int i = lo; i <= hi; i++) if (i >= outq.size() || outq[i] !== 32'h0) z = 1'b0;
    return z;
  endfunction

  // Byte-level reference of the padded message.
  function automatic logic [31:0] model_word(input int n, input int tot_bytes, input int w);
    logic [31:0] r;
    logic [63:0] l;
    logic [7:0]  by;
    int bi;
    int k;
    l = 64'(n) * 64'd8;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      bi = w * 4 + j;
      if (bi < n)                    by = 8'((bi % 4) + 1);
      else if (bi == n)              by = 8'h80;
      else if (bi >= tot_bytes - 8) begin
        k  = bi - (tot_bytes - 8);
        by = l[63 - 8 * k -: 8];
      end else                       by = 8'h00;
      r[31 - 8 * j -: 8] = by;
    end
    return r;
  endfunction

  task automatic check_model(input int n);
    int words;
    int nl;
    words = ((n + 9 + 63) / 64) * 16;
    chk($sformatf("size_n%0d", n), 64'(outq.size()), 64'(words));
    nl = 0;
    foreach (outlst[i]) if (outlst[i]) nl++;
    chk($sformatf("lst_count_n%0d", n), 64'(nl), 64'd1);
    if (outq.size() == words) begin
      chk($sformatf("lst_pos_n%0d", n), 64'(outlst[words - 1]), 64'd1);
      for (int w = 0; w < words; w++)
        chk($sformatf("n%0d_w%0d", n, w), 64'(outq[w]), 64'(model_word(n, words * 4, w)));
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    pad_otpt_ena      = 1'b0;
    msg_inpt_d        = '0;
    msg_inpt_vld_byte = '0;
    msg_inpt_vld      = 1'b0;
    msg_inpt_lst      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", pad_otpt_vld, 1'b0);
    chk("rst_d", pad_otpt_d, 32'h0);
    chk("rst_lst", pad_otpt_lst, 1'b0);
    chk("rst_rdy_ena0", msg_inpt_rdy, 1'b0);
    pad_otpt_ena = 1'b1;
    #1;
    chk("idle_rdy_ena1", msg_inpt_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1 byte: latency, PAD blocks input, single block.
    clr();
    send_msg(1);
    chk("t1_first_vld", pad_otpt_vld, 1'b1);
    chk("t1_first_d", pad_otpt_d, 32'h01800000);
    chk("t1_rdy_in_pad", msg_inpt_rdy, 1'b0);
    wait_lst();
    chk("t1_size", 64'(outq.size()), 64'd16);
    chk("t1_w0", outq[0], 32'h01800000);
    chk("t1_zero", zero_span(1, 14), 1'b1);
    chk("t1_w15", outq[15], 32'h00000008);
    chk("t1_lst15", outlst[15], 1'b1);

    run_msg(4);
    chk("t4_size", 64'(outq.size()), 64'd16);
    chk("t4_w0", outq[0], 32'h01020304);
    chk("t4_w1", outq[1], 32'h80000000);
    chk("t4_zero", zero_span(2, 14), 1'b1);
    chk("t4_w15", outq[15], 32'h00000020);

    run_msg(56);
    chk("t56_size", 64'(outq.size()), 64'd32);
    chk("t56_w13", outq[13], 32'h01020304);
    chk("t56_w14", outq[14], 32'h80000000);
    chk("t56_w15", outq[15], 32'h0);
    chk("t56_zero", zero_span(16, 30), 1'b1);
    chk("t56_w31", outq[31], 32'h000001C0);

    run_msg(64);
    chk("t64_size", 64'(outq.size()), 64'd32);
    chk("t64_w15", outq[15], 32'h01020304);
    chk("t64_w16", outq[16], 32'h80000000);
    chk("t64_zero", zero_span(17, 30), 1'b1);
    chk("t64_w31", outq[31], 32'h00000200);

    run_msg(63);
    chk("t63_size", 64'(outq.size()), 64'd32);
    chk("t63_w15", outq[15], 32'h01020380);
    chk("t63_zero", zero_span(16, 30), 1'b1);
    chk("t63_w31", outq[31], 32'h000001F8);
    chk("t63_lst_only_end", outlst[15], 1'b0);

    // Partial last beat ending right before the length slot, and one
    // ending inside it.
    run_msg(55);
    check_model(55);
    run_msg(59);
    check_model(59);

    // Reset in the middle of a message discards it.
    clr();
    msg_inpt_d        = 32'h01020304;
    msg_inpt_vld_byte = 4'hF;
    msg_inpt_lst      = 1'b0;
    msg_inpt_vld      = 1'b1;
    repeat (3) wait_accept();
    msg_inpt_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", pad_otpt_vld, 1'b0);
    chk("midrst_d", pad_otpt_d, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_msg(1);
    chk("after_rst_size", 64'(outq.size()), 64'd16);
    chk("after_rst_w0", outq[0], 32'h01800000);
    chk("after_rst_w15", outq[15], 32'h00000008);

    // Random lengths with ena toggling.
    rand_mode = 1;
    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(1, 6400);
      run_msg(n);
      check_model(n);
    end
    rand_mode = 0;
    @(posedge clk);
    #2;
    pad_otpt_ena = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
